log_reservation_station: RTL
============================

# log_reservation_station

Reservation station directly upstream of the logical execution unit. Holds dispatched logical-class instructions, snoops the common result bus for missing source operands, and issues operand-complete entries to the logical unit over a valid/ready handshake. An entry's tag (`rs_id`) stays allocated until its own result appears on the result bus, so tags are never reused while in flight.

## Interface
- `RS_ID_WIDTH`, 5: width of all producer tags.
- `RS_OFFSET`, 0: tag of entry 0; entry i owns tag `RS_OFFSET+i`.
- `DEPTH`, 4: number of entries, 2..8.
- `clk`  in  1  clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dispatch_valid`  in  1  dispatch request.
- `dispatch_ready`  out  1  at least one entry is FREE.
- `dispatch_op1`, `dispatch_op2`  in  `rs_operand_t` each  {value[0:31], tag[0:RS_ID_WIDTH-1], valid}.
- `dispatch_control`  in  `log_decode_t`  operation select and `alter_CR0`.
- `dispatch_reg_addr`  in  5  destination GPR.
- `cdb_valid`  in  1  result-bus broadcast.
- `cdb_rs_id`  in  RS_ID_WIDTH  producer tag.
- `cdb_result`  in  32  broadcast value.
- `issue_valid`  out  1  an entry is READY.
- `issue_ready`  in  1  the logical unit accepts the issue.
- `issue_rs_id`  out  RS_ID_WIDTH  tag of the issued entry.
- `issue_reg_addr`  out  5  destination GPR.
- `issue_op1`, `issue_op2`  out  32  operand values.
- `issue_control`  out  `log_decode_t`  operation select.

## Operation
- Entry states: FREE, WAITING (an operand is missing), READY, ISSUED.
- **Dispatch.** When `dispatch_valid & dispatch_ready`, the lowest-index FREE entry is written.
  - An operand is captured as valid if its `valid` is set, or if `cdb_valid` is high in the same cycle with `cdb_rs_id` equal to its tag. In the bus-match case, `cdb_result` is stored.
  - The entry goes to READY if both operands are valid, otherwise to WAITING.
- **Snoop.** Each cycle, every WAITING operand whose tag equals `cdb_rs_id` while `cdb_valid` is high captures `cdb_result`. An entry whose last missing operand is captured goes WAITING→READY.
- **Issue.**
  - `issue_valid` is high when any entry is READY. The selected entry drives all `issue_*` outputs.
  - On `issue_valid & issue_ready`, the selected entry goes READY→ISSUED.
  - While `issue_ready` is low, the selection and all `issue_*` outputs stay stable.
- **Release.** When `cdb_valid` is high and `cdb_rs_id` equals an ISSUED entry's own tag, that entry goes ISSUED→FREE.
- **Foreign tags.** Tags outside `RS_OFFSET..RS_OFFSET+DEPTH-1` never free an entry. They only wake operands.
- **Outputs not driven.** When `issue_valid` is 0, all `issue_*` data outputs are 0.

## Timing
- **Reset.** Asserting `rst_n` low immediately sets every entry to FREE, at any point mid-operation. After reset: `dispatch_ready`=1, `issue_valid`=0, all `issue_*` outputs 0, stored operands 0.
- **Dispatch to issue.** Dispatch with both operands ready in cycle N: `issue_valid` is high in N+1 at the earliest.
- **Wakeup to issue.** A bus wakeup in cycle N: the entry is issuable in N+1.
- **Full.** `dispatch_ready` is computed from registered state only. An entry freed in cycle N becomes dispatchable in N+1. A full station holds `dispatch_ready`=0.
- **Simultaneous events in one cycle.**
  - Dispatch, snoop, issue and release to different entries all take effect.
  - Two operands with the same tag both capture the value.
  - A release and a wakeup on the same broadcast both take effect.
- **Throughput.** One dispatch and one issue per cycle.

## Configuration
- `LOG_RS_OLDEST_FIRST_EN` defined: the oldest READY entry is selected for issue, where age is dispatch order. Age is tracked with a DEPTH×DEPTH age matrix, updated on dispatch and cleared on release.
- `LOG_RS_OLDEST_FIRST_EN` not defined: the lowest-index READY entry is selected, and no age state is built.
- In both cases the selection holds while an issue is stalled.

## Structure
- **Shared package `ppc_types`:** add `rs_operand_t` and `rs_state_t` (FREE/WAITING/READY/ISSUED). `log_decode_t` is already there.
- **Sub-module `rs_issue_select`:** takes DEPTH ready bits plus the optional age matrix and returns a one-hot grant and an index. It is reused by the other stations.

## Test plan
- **Ready dispatch:** dispatch op1=0xF0F0F0F0, op2=0x0FF00FF0, both valid, `issue_ready`=1 → `issue_valid` in the next cycle with those values and `issue_rs_id`=`RS_OFFSET`. A broadcast on that tag then frees the entry.
- **Wakeup:** dispatch with op2 waiting on tag 9; then `cdb_valid`, tag 9, value 0x12345678 → issue the next cycle with op2=0x12345678.
- **Same-cycle capture:** dispatch waiting on tag 7 while tag 7 is broadcasting 0xDEADBEEF → entry READY and issued the next cycle with 0xDEADBEEF.
- **Full and stall:** DEPTH=4, fill 4 entries with `issue_ready`=0 → `dispatch_ready`=0 and `issue_*` outputs stable. Raise `issue_ready`, then broadcast tag `RS_OFFSET+2` → `dispatch_ready`=1 one cycle later.
- **Ordering:** dispatch into entries 3 then 1 (1 freed later) → with `LOG_RS_OLDEST_FIRST_EN` entry 3 issues first; without it, entry 1.
- **Reset mid-operation:** drive `rst_n` low with 3 entries WAITING → `issue_valid`=0 and `dispatch_ready`=1 immediately, and a later broadcast wakes nothing.

Source files
------------

// File: rtl/ppc_types.sv
// ppc_types: shared pipeline types for the PowerPC core (decode records, reservation-station operands and entry states).
package ppc_types;
  localparam int RS_TAG_W = 5;
  typedef enum logic [2:0] {
    LOG_AND, LOG_OR, LOG_XOR, LOG_NAND, LOG_NOR, LOG_EQV, LOG_ANDC, LOG_ORC
  } log_op_t;
  typedef struct packed {
    log_op_t op;
    logic    alter_CR0;
  } log_decode_t;
  typedef struct packed {
    logic [0:31]         value;
    logic [0:RS_TAG_W-1] tag;
    logic                valid;
  } rs_operand_t;
  typedef enum logic [1:0] {RS_FREE, RS_WAITING, RS_READY, RS_ISSUED} rs_state_t;
endpackage

// File: rtl/rs_issue_select.sv
// rs_issue_select: picks one READY entry, oldest-first from an age matrix (age[i][j]=1: i older than j) or lowest-index.
// Ports: ready (per-entry READY), age (DEPTH x DEPTH), grant (one-hot), index (binary of grant).
module rs_issue_select #(
  parameter int DEPTH = 4,
  parameter bit OLDEST = 1'b0,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  output logic [DEPTH-1:0]            grant,
  output logic [IW-1:0]               index
);
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    logic [DEPTH-1:0] beats;
    for (genvar j = 0; j < DEPTH; j++) begin : g_col
      assign beats[j] = (i == j) || !ready[j] || (OLDEST ? age[i][j] : i < j);
    end
    assign grant[i] = ready[i] && &beats;
  end
  always_comb begin
    index = '0;
    for (int i = 0; i < DEPTH; i++) index = grant[i] ? IW'(i) : index;
  end
endmodule

// File: rtl/log_reservation_station.sv
// log_reservation_station: holds logical-class instructions, snoops the result bus for operands, issues to the logical unit.
// Ports: clk, rst_n (async active-low); dispatch_* (valid/ready, operands, control, dest GPR);
//        cdb_* (result-bus broadcast: wakes operands and releases ISSUED entries by own tag);
//        issue_* (valid/ready handshake to the logical unit, zero when issue_valid is low).
// Build option: define LOG_RS_OLDEST_FIRST_EN for oldest-first issue (age matrix); otherwise lowest-index first.
module log_reservation_station
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_OFFSET = 0,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  rs_operand_t            dispatch_op1,
  input  rs_operand_t            dispatch_op2,
  input  log_decode_t            dispatch_control,
  input  logic [4:0]             dispatch_reg_addr,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] issue_rs_id,
  output logic [4:0]             issue_reg_addr,
  output logic [31:0]            issue_op1,
  output logic [31:0]            issue_op2,
  output log_decode_t            issue_control
);
  localparam int IW = $clog2(DEPTH);
  rs_state_t st [DEPTH];
  rs_operand_t op1 [DEPTH], op2 [DEPTH], w1 [DEPTH], w2 [DEPTH];
  rs_operand_t d1, d2;
  log_decode_t ctl [DEPTH];
  logic [4:0] rd [DEPTH];
  logic [DEPTH-1:0] free, ready, rel, grant;
  logic [DEPTH-1:0][DEPTH-1:0] age;
  logic [IW-1:0] alloc, pick, sel, held_idx;
  logic held, dispatch_fire, issue_fire;
  function automatic rs_operand_t snoop(rs_operand_t op);
    return (!op.valid && cdb_valid && op.tag == RS_TAG_W'(cdb_rs_id)) ? {cdb_result, op.tag, 1'b1} : op;
  endfunction
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign free[i] = st[i] == RS_FREE;
    assign ready[i] = st[i] == RS_READY;
    assign rel[i] = st[i] == RS_ISSUED && cdb_valid && cdb_rs_id == RS_ID_WIDTH'(RS_OFFSET + i);
    assign w1[i] = snoop(op1[i]);
    assign w2[i] = snoop(op2[i]);
  end
  assign d1 = snoop(dispatch_op1);
  assign d2 = snoop(dispatch_op2);
  always_comb begin
    alloc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) alloc = free[i] ? IW'(i) : alloc;
  end
  assign dispatch_ready = |free;
  assign dispatch_fire = dispatch_valid & dispatch_ready;
  assign issue_valid = |grant;
  // A stalled issue keeps its entry even if an older or lower entry wakes meanwhile.
  assign sel = held ? held_idx : pick;
  assign issue_fire = issue_valid & issue_ready;
  assign issue_rs_id = issue_valid ? RS_ID_WIDTH'(RS_OFFSET + int'(sel)) : '0;
  assign issue_reg_addr = issue_valid ? rd[sel] : '0;
  assign issue_op1 = issue_valid ? op1[sel].value : '0;
  assign issue_op2 = issue_valid ? op2[sel].value : '0;
  assign issue_control = issue_valid ? ctl[sel] : '0;
`ifdef LOG_RS_OLDEST_FIRST_EN
  localparam bit OLDEST = 1'b1;
  // Every occupied entry is older than the one being written; release forgets both row and column.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age <= '0;
    else
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < DEPTH; j++)
          if (rel[i] || rel[j] || (dispatch_fire && alloc == IW'(i))) age[i][j] <= 1'b0;
          else if (dispatch_fire && alloc == IW'(j)) age[i][j] <= !free[i];
`else
  localparam bit OLDEST = 1'b0;
  assign age = '0;
`endif
  rs_issue_select #(.DEPTH(DEPTH), .OLDEST(OLDEST)) u_sel (
    .ready(ready),
    .age(age),
    .grant(grant),
    .index(pick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= '{default: RS_FREE};
      op1 <= '{default: '0};
      op2 <= '{default: '0};
      ctl <= '{default: '0};
      rd <= '{default: '0};
      held <= 1'b0;
      held_idx <= '0;
    end else begin
      held <= issue_valid & ~issue_ready;
      held_idx <= sel;
      for (int i = 0; i < DEPTH; i++) begin
        if (st[i] == RS_WAITING) begin
          op1[i] <= w1[i];
          op2[i] <= w2[i];
          st[i] <= (w1[i].valid && w2[i].valid) ? RS_READY : RS_WAITING;
        end
        if (issue_fire && sel == IW'(i)) st[i] <= RS_ISSUED;
        if (rel[i]) st[i] <= RS_FREE;
        if (dispatch_fire && alloc == IW'(i)) begin
          op1[i] <= d1;
          op2[i] <= d2;
          ctl[i] <= dispatch_control;
          rd[i] <= dispatch_reg_addr;
          st[i] <= (d1.valid && d2.valid) ? RS_READY : RS_WAITING;
        end
      end
    end
endmodule
